intra_nxn_pred_mode_seq: RTL and testbench

- Sequential successor of the combinational Intra4x4 mode derivation, owned per macroblock.
- Derives Intra4x4PredMode (16 blocks) or Intra8x8PredMode (4 blocks) from prev/rem syntax elements.
- Holds the current-MB mode array, the left-column modes and an up-row line buffer spanning the picture width.
- Sits between the slice-data parser and intra prediction; non-NxN MBs still update neighbour state, with DC = 2.

---
 rtl/intra_nxn_pred_mode_seq_pkg.sv | 35 +++
 rtl/intra_nxn_pred_mode_seq_mpm.sv | 35 +++
 rtl/intra_nxn_pred_mode_seq.sv | 226 ++++++++++++++++++++++
 tb/tb_intra_nxn_pred_mode_seq.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/intra_nxn_pred_mode_seq_pkg.sv
// Shared types and constants for the per-macroblock Intra4x4/8x8 mode sequencer.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package intra_nxn_pred_mode_seq_pkg;

  // Default field widths for MB coordinates
  localparam int MB_X_BITS = 7;
  localparam int MB_Y_BITS = 7;

  // Macroblock kind codes as delivered by the slice-data parser
  localparam logic [1:0] KIND_I4X4  = 2'd0;
  localparam logic [1:0] KIND_I8X8  = 2'd1;
  localparam logic [1:0] KIND_OTHER = 2'd2;

  // DC prediction mode, used for unavailable neighbours and non-NxN MBs
  localparam logic [3:0] MODE_DC = 4'd2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_PRED,
    ST_OUT,
    ST_COMMIT
  } state_t;

  // Top-left 4x4 position of a block inside the MB, packed as {y[1:0], x[1:0]}.
  // Doubles as the index into the 16-entry current-MB mode array.
  function automatic logic [3:0] blk_pos(input logic is_8x8, input logic [3:0] blk);
    if (is_8x8) begin
      return {blk[1], 1'b0, blk[0], 1'b0};
    end
    return {blk[3], blk[1], blk[2], blk[0]};
  endfunction

endpackage

// File: rtl/intra_nxn_pred_mode_seq_mpm.sv
// Most-probable-mode selection and rem_intraNxN_pred_mode remapping.
// Latency: combinational.
// Backpressure: none; pure function of its inputs.
module intra_mpm_calc
  import intra_nxn_pred_mode_seq_pkg::*;
(
  input  logic [3:0] i_left,
  input  logic [3:0] i_up,
  input  logic       i_left_av,
  input  logic       i_up_av,
  input  logic       i_prev_flag,
  input  logic [2:0] i_rem_mode,
  output logic [3:0] o_mode
);

  logic [3:0] w_mpm;
  logic [3:0] w_rem;

  // mpm falls back to DC unless both neighbours exist; rem skips over mpm
  always_comb begin
    w_mpm = MODE_DC;
    if (i_left_av && i_up_av) begin
      w_mpm = (i_left < i_up) ? i_left : i_up;
    end
    w_rem = {1'b0, i_rem_mode};
    if (i_prev_flag) begin
      o_mode = w_mpm;
    end else if (w_rem >= w_mpm) begin
      o_mode = w_rem + 4'd1;
    end else begin
      o_mode = w_rem;
    end
  end

endmodule

// File: rtl/intra_nxn_pred_mode_seq.sv
// Per-MB Intra4x4/Intra8x8 prediction-mode derivation with left/up neighbour state.
// Latency: mode_out registered one cycle after the syntax element; 2 cycles per block.
// Backpressure: OUT holds mode_out/blk_idx_out until mode_ready; se_ready only in PRED.
module intra_nxn_pred_mode_seq
  import intra_nxn_pred_mode_seq_pkg::*;
#(
  parameter int MAX_MB_W = 120,
  parameter int MBX_BITS = MB_X_BITS,
  parameter int MBY_BITS = MB_Y_BITS
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         mb_start,
  output logic                         mb_ready,
  input  logic [MBX_BITS-1:0]          mb_x,
  input  logic [MBY_BITS-1:0]          mb_y,
  input  logic [MBX_BITS+MBY_BITS-1:0] slice_mb_index,
  input  logic [MBX_BITS:0]            pic_width_in_mbs,
  input  logic [1:0]                   mb_kind,
  input  logic                         se_valid,
  output logic                         se_ready,
  input  logic                         prev_flag,
  input  logic [2:0]                   rem_mode,
  output logic                         mode_valid,
  input  logic                         mode_ready,
  output logic [3:0]                   mode_out,
  output logic [3:0]                   blk_idx_out,
  output logic                         mb_done
);

  state_t r_state;
  state_t w_state_nxt;

  logic [MBX_BITS-1:0] r_mb_x;
  logic [1:0]          r_kind;
  logic                r_up_a;
  logic                r_left_a;
  logic [3:0]          r_blk;
  logic [3:0]          r_mode_out;

  // Current MB modes indexed {y,x}; left column and up row of neighbours
  logic [3:0]  r_cur  [16];
  logic [3:0]  r_left [4];
  logic [3:0]  r_up   [4];
  // Bottom-row modes of the MB row above, entry x at bits [4x+3:4x]
  logic [15:0] r_lbuf [MAX_MB_W];

  logic        w_is_8x8;
  logic [3:0]  w_pos;
  logic [1:0]  w_x;
  logic [1:0]  w_y;
  logic [3:0]  w_left;
  logic [3:0]  w_up;
  logic        w_left_av;
  logic        w_up_av;
  logic [3:0]  w_mode;
  logic        w_last;
  logic [15:0] w_wr_mask;
  logic [15:0] w_row3;
  logic [15:0] w_lbuf_rd;
  logic        w_up_a_in;
  logic        w_left_a_in;

  assign w_is_8x8 = (r_kind == KIND_I8X8);
  assign w_pos    = blk_pos(w_is_8x8, r_blk);
  assign w_x      = w_pos[1:0];
  assign w_y      = w_pos[3:2];

  // Edge blocks look outside the MB; interior neighbours are always present
  assign w_left    = (w_x != 2'd0) ? r_cur[{w_y, w_x - 2'd1}] : r_left[w_y];
  assign w_up      = (w_y != 2'd0) ? r_cur[{w_y - 2'd1, w_x}] : r_up[w_x];
  assign w_left_av = (w_x != 2'd0) | r_left_a;
  assign w_up_av   = (w_y != 2'd0) | r_up_a;

  assign w_last = w_is_8x8 ? (r_blk == 4'd3) : (r_blk == 4'd15);

  // The MB above must lie in this slice: its index is one picture width back
  assign w_up_a_in   = (mb_y != '0) &&
                       (slice_mb_index >= {{(MBY_BITS-1){1'b0}}, pic_width_in_mbs});
  assign w_left_a_in = (mb_x != '0) && (slice_mb_index != '0);

  // Non-NxN MBs present an all-DC MB to their right and lower neighbours
  assign w_row3    = r_kind[1] ? {4{MODE_DC}} : {r_cur[15], r_cur[14], r_cur[13], r_cur[12]};
  assign w_lbuf_rd = r_lbuf[r_mb_x];

  assign mode_out    = r_mode_out;
  assign blk_idx_out = r_blk;

  intra_mpm_calc u_mpm (
    .i_left      (w_left),
    .i_up        (w_up),
    .i_left_av   (w_left_av),
    .i_up_av     (w_up_av),
    .i_prev_flag (prev_flag),
    .i_rem_mode  (rem_mode),
    .o_mode      (w_mode)
  );

  // 4x4 positions covered by the current block (four for an 8x8)
  always_comb begin
    w_wr_mask = '0;
    w_wr_mask[{w_y, w_x}] = 1'b1;
    if (w_is_8x8) begin
      w_wr_mask[{w_y, w_x | 2'd1}]          = 1'b1;
      w_wr_mask[{w_y | 2'd1, w_x}]          = 1'b1;
      w_wr_mask[{w_y | 2'd1, w_x | 2'd1}]   = 1'b1;
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next state and handshake outputs
  always_comb begin
    w_state_nxt = r_state;
    mb_ready    = 1'b0;
    se_ready    = 1'b0;
    mode_valid  = 1'b0;
    mb_done     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        mb_ready = 1'b1;
        if (mb_start) begin
          w_state_nxt = ST_LOAD;
        end
      end
      ST_LOAD: begin
        w_state_nxt = r_kind[1] ? ST_COMMIT : ST_PRED;
      end
      ST_PRED: begin
        se_ready = 1'b1;
        if (se_valid) begin
          w_state_nxt = ST_OUT;
        end
      end
      ST_OUT: begin
        mode_valid = 1'b1;
        if (mode_ready) begin
          w_state_nxt = w_last ? ST_COMMIT : ST_PRED;
        end
      end
      ST_COMMIT: begin
        mb_done     = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Per-MB context, mode arrays and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mb_x     <= '0;
      r_kind     <= KIND_I4X4;
      r_up_a     <= 1'b0;
      r_left_a   <= 1'b0;
      r_blk      <= 4'd0;
      r_mode_out <= 4'd0;
      for (int k = 0; k < 16; k++) begin
        r_cur[4'(k)] <= MODE_DC;
      end
      for (int k = 0; k < 4; k++) begin
        r_left[2'(k)] <= MODE_DC;
        r_up[2'(k)]   <= MODE_DC;
      end
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (mb_start) begin
            r_mb_x   <= mb_x;
            r_kind   <= mb_kind;
            r_up_a   <= w_up_a_in;
            r_left_a <= w_left_a_in;
            r_blk    <= 4'd0;
          end
        end
        ST_LOAD: begin
          for (int k = 0; k < 4; k++) begin
            r_up[2'(k)] <= w_lbuf_rd[4*k +: 4];
          end
        end
        ST_PRED: begin
          if (se_valid) begin
            r_mode_out <= w_mode;
            for (int k = 0; k < 16; k++) begin
              if (w_wr_mask[4'(k)]) begin
                r_cur[4'(k)] <= w_mode;
              end
            end
          end
        end
        ST_OUT: begin
          if (mode_ready && !w_last) begin
            r_blk <= r_blk + 4'd1;
          end
        end
        ST_COMMIT: begin
          for (int k = 0; k < 4; k++) begin
            r_left[2'(k)] <= r_kind[1] ? MODE_DC : r_cur[4'(4*k + 3)];
          end
          for (int k = 0; k < 16; k++) begin
            r_cur[4'(k)] <= MODE_DC;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Line buffer keeps its contents through reset; availability masks stale entries
  always_ff @(posedge clk) begin
    if (!rst && (r_state == ST_COMMIT)) begin
      r_lbuf[r_mb_x] <= w_row3;
    end
  end

endmodule

// File: tb/tb_intra_nxn_pred_mode_seq.sv
// Self-checking bench: picture-level mode map predicts each block's mode.
// Latency: n/a (testbench).
// Backpressure: bench stalls mode_ready to exercise OUT hold.
module tb_intra_nxn_pred_mode_seq;

  localparam int PW = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        mb_start;
  logic        mb_ready;
  logic [6:0]  mb_x;
  logic [6:0]  mb_y;
  logic [13:0] slice_mb_index;
  logic [7:0]  pic_width_in_mbs;
  logic [1:0]  mb_kind;
  logic        se_valid;
  logic        se_ready;
  logic        prev_flag;
  logic [2:0]  rem_mode;
  logic        mode_valid;
  logic        mode_ready;
  logic [3:0]  mode_out;
  logic [3:0]  blk_idx_out;
  logic        mb_done;

  always #5 clk = ~clk;

  intra_nxn_pred_mode_seq #(.MAX_MB_W(120), .MBX_BITS(7), .MBY_BITS(7)) dut (
    .clk              (clk),
    .rst              (rst),
    .mb_start         (mb_start),
    .mb_ready         (mb_ready),
    .mb_x             (mb_x),
    .mb_y             (mb_y),
    .slice_mb_index   (slice_mb_index),
    .pic_width_in_mbs (pic_width_in_mbs),
    .mb_kind          (mb_kind),
    .se_valid         (se_valid),
    .se_ready         (se_ready),
    .prev_flag        (prev_flag),
    .rem_mode         (rem_mode),
    .mode_valid       (mode_valid),
    .mode_ready       (mode_ready),
    .mode_out         (mode_out),
    .blk_idx_out      (blk_idx_out),
    .mb_done          (mb_done)
  );

  typedef struct {
    int blk;
    int mode;
  } exp_t;

  exp_t exp_q[$];
  int   pic_mode [0:7][0:15];
  int   tb_prev  [16];
  int   tb_rem   [16];
  int   got_mode [16];
  int   checks = 0;
  int   passes = 0;

  // Reference: modes held per 4x4 in picture coordinates; availability from slice geometry
  task automatic model_mb(input int x, input int y, input int idx, input int kind);
    int n, bx, by, gx, gy, lm, um, mpm, md, sz;
    bit la, ua;
    if (kind >= 2) begin
      for (int i = 0; i < 4; i++)
        for (int j = 0; j < 4; j++)
          pic_mode[x*4+i][y*4+j] = 2;
      return;
    end
    n  = (kind == 1) ? 4 : 16;
    sz = (kind == 1) ? 2 : 1;
    for (int b = 0; b < n; b++) begin
      if (kind == 1) begin
        bx = (b % 2) * 2;
        by = (b / 2) * 2;
      end else begin
        bx = ((b >> 2) & 1) * 2 + (b & 1);
        by = ((b >> 3) & 1) * 2 + ((b >> 1) & 1);
      end
      gx  = x*4 + bx;
      gy  = y*4 + by;
      la  = (bx > 0) || (x > 0 && idx > 0);
      ua  = (by > 0) || (y > 0 && idx >= PW);
      mpm = 2;
      if (la && ua) begin
        lm  = pic_mode[gx-1][gy];
        um  = pic_mode[gx][gy-1];
        mpm = (lm < um) ? lm : um;
      end
      if (tb_prev[b] != 0)      md = mpm;
      else if (tb_rem[b] >= mpm) md = tb_rem[b] + 1;
      else                       md = tb_rem[b];
      for (int i = 0; i < sz; i++)
        for (int j = 0; j < sz; j++)
          pic_mode[gx+i][gy+j] = md;
      exp_q.push_back('{b, md});
    end
  endtask

  task automatic fill_rand();
    for (int b = 0; b < 16; b++) begin
      tb_prev[b] = int'($urandom_range(0, 1));
      tb_rem[b]  = int'($urandom_range(0, 7));
    end
  endtask

  // Drive one MB, compare each derived mode against the scoreboard as it appears
  task automatic run_mb(input int x, input int y, input int idx, input int kind, input bit hold);
    int   n, cnt;
    exp_t e;
    logic [3:0] mo, bo;
    bit   stable;
    n = (kind == 0) ? 16 : ((kind == 1) ? 4 : 0);
    cnt = 0;
    while (mb_ready !== 1'b1 && cnt < 20) begin @(posedge clk); #1; cnt++; end
    checks++;
    if (mb_ready !== 1'b1) $display("FAIL mb_ready_wait: mb_ready=%b required 1", mb_ready);
    else passes++;
    model_mb(x, y, idx, kind);
    mb_x = 7'(x); mb_y = 7'(y); slice_mb_index = 14'(idx); mb_kind = 2'(kind);
    mb_start = 1'b1;
    @(posedge clk); #1;
    mb_start = 1'b0;
    mb_kind  = 2'd3;
    for (int b = 0; b < n; b++) begin
      cnt = 0;
      while (se_ready !== 1'b1 && cnt < 20) begin @(posedge clk); #1; cnt++; end
      if (se_ready !== 1'b1) begin
        checks++;
        $display("FAIL se_ready_wait blk %0d: se_ready=%b required 1", b, se_ready);
        break;
      end
      se_valid  = 1'b1;
      prev_flag = tb_prev[b][0];
      rem_mode  = 3'(tb_rem[b]);
      @(posedge clk); #1;
      se_valid = 1'b0;
      if (hold && b == 0) begin
        mo = mode_out; bo = blk_idx_out; stable = 1'b1;
        se_valid = 1'b1; prev_flag = 1'b0; rem_mode = 3'd7; mb_start = 1'b1;
        repeat (5) begin
          @(posedge clk); #1;
          if (mode_out !== mo || blk_idx_out !== bo || se_ready !== 1'b0 ||
              mode_valid !== 1'b1 || mb_ready !== 1'b0) stable = 1'b0;
        end
        mb_start = 1'b0;
        checks++;
        if (!stable) $display("FAIL stall_hold: mode_out=%0d blk=%0d se_ready=%b mode_valid=%b required %0d %0d 0 1",
                              mode_out, blk_idx_out, se_ready, mode_valid, mo, bo);
        else passes++;
      end
      checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL scoreboard_empty blk %0d: queue size 0 required >0", b);
      end else begin
        e = exp_q.pop_front();
        if (mode_valid !== 1'b1 || mode_out !== 4'(e.mode) || blk_idx_out !== 4'(e.blk))
          $display("FAIL mode MB(%0d,%0d) blk %0d: valid=%b mode=%0d blk=%0d required 1 %0d %0d",
                   x, y, b, mode_valid, mode_out, blk_idx_out, e.mode, e.blk);
        else passes++;
      end
      got_mode[b] = int'(mode_out);
      mode_ready = 1'b1;
      @(posedge clk); #1;
      mode_ready = 1'b0;
      se_valid   = 1'b0;
    end
    cnt = 0;
    while (mb_done !== 1'b1 && cnt < 20) begin @(posedge clk); #1; cnt++; end
    checks++;
    if (mb_done !== 1'b1) $display("FAIL mb_done MB(%0d,%0d): mb_done=%b required 1", x, y, mb_done);
    else passes++;
    @(posedge clk); #1;
    checks++;
    if (mb_done !== 1'b0 || mb_ready !== 1'b1 || exp_q.size() != 0)
      $display("FAIL mb_end MB(%0d,%0d): mb_done=%b mb_ready=%b left=%0d required 0 1 0",
               x, y, mb_done, mb_ready, exp_q.size());
    else passes++;
  endtask

  task automatic test_reset();
    checks++;
    if (mb_ready !== 1'b1 || se_ready !== 1'b0 || mode_valid !== 1'b0 || mb_done !== 1'b0 ||
        mode_out !== 4'd0 || blk_idx_out !== 4'd0)
      $display("FAIL reset_state: rdy=%b se=%b mv=%b done=%b mode=%0d blk=%0d required 1 0 0 0 0 0",
               mb_ready, se_ready, mode_valid, mb_done, mode_out, blk_idx_out);
    else passes++;
  endtask

  task automatic test_first_mb();
    bit all_dc;
    for (int b = 0; b < 16; b++) begin tb_prev[b] = 1; tb_rem[b] = b % 8; end
    run_mb(0, 0, 0, 0, 1'b0);
    all_dc = 1'b1;
    for (int b = 0; b < 16; b++) if (got_mode[b] != 2) all_dc = 1'b0;
    checks++;
    if (!all_dc) $display("FAIL first_mb_dc: blk0=%0d blk15=%0d required all 2", got_mode[0], got_mode[15]);
    else passes++;
  endtask

  task automatic test_left_only();
    fill_rand();
    tb_prev[0] = 0; tb_rem[0] = 0;
    tb_prev[2] = 0; tb_rem[2] = 2;
    run_mb(1, 0, 1, 0, 1'b0);
    checks++;
    if (got_mode[0] != 0 || got_mode[2] != 3)
      $display("FAIL left_only: blk0=%0d blk2=%0d required 0 3", got_mode[0], got_mode[2]);
    else passes++;
  endtask

  task automatic test_row_wrap();
    fill_rand();
    tb_prev[0] = 1; tb_prev[1] = 1;
    run_mb(0, 1, 2, 0, 1'b0);
    checks++;
    if (got_mode[0] != 2 || got_mode[1] != 2)
      $display("FAIL row_wrap: blk0=%0d blk1=%0d required 2 2", got_mode[0], got_mode[1]);
    else passes++;
  endtask

  task automatic test_i8x8();
    fill_rand();
    tb_prev[0] = 1;
    run_mb(1, 1, 3, 1, 1'b0);
  endtask

  task automatic test_other_then_stall();
    run_mb(0, 2, 4, 2, 1'b0);
    fill_rand();
    tb_prev[0] = 1;
    run_mb(1, 2, 5, 0, 1'b1);
  endtask

  task automatic test_reset_mid();
    int cnt;
    mb_x = 7'd0; mb_y = 7'd3; slice_mb_index = 14'd6; mb_kind = 2'd0;
    mb_start = 1'b1;
    @(posedge clk); #1;
    mb_start = 1'b0;
    cnt = 0;
    while (se_ready !== 1'b1 && cnt < 20) begin @(posedge clk); #1; cnt++; end
    se_valid = 1'b1; prev_flag = 1'b0; rem_mode = 3'd5;
    @(posedge clk); #1;
    se_valid = 1'b0;
    checks++;
    if (mode_valid !== 1'b1) $display("FAIL pre_reset_out: mode_valid=%b required 1", mode_valid);
    else passes++;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if (mode_valid !== 1'b0 || mb_ready !== 1'b1 || se_ready !== 1'b0 || mb_done !== 1'b0 ||
        mode_out !== 4'd0 || blk_idx_out !== 4'd0)
      $display("FAIL reset_mid: mv=%b rdy=%b se=%b done=%b mode=%0d blk=%0d required 0 1 0 0 0 0",
               mode_valid, mb_ready, se_ready, mb_done, mode_out, blk_idx_out);
    else passes++;
  endtask

  task automatic test_back_to_back();
    fill_rand();
    run_mb(0, 0, 0, 0, 1'b0);
    fill_rand();
    run_mb(1, 0, 1, 1, 1'b0);
    fill_rand();
    run_mb(0, 1, 2, 1, 1'b0);
    fill_rand();
    run_mb(1, 1, 3, 0, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    mb_start = 1'b0; mb_x = '0; mb_y = '0; slice_mb_index = '0;
    pic_width_in_mbs = 8'(PW); mb_kind = 2'd0;
    se_valid = 1'b0; prev_flag = 1'b0; rem_mode = 3'd0; mode_ready = 1'b0;
    for (int i = 0; i < 8; i++) for (int j = 0; j < 16; j++) pic_mode[i][j] = 2;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    test_reset();
    test_first_mb();
    test_left_only();
    test_row_wrap();
    test_i8x8();
    test_other_then_stall();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
